mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and resetn.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- resetn  in  1  async active-low reset
- aluResult  in  32  effective address / ALU value from EX/MEM
- aluOperand2  in  32  store data from EX/MEM
- rd  in  5  destination register
- memSize  in  3  funct3 size code
- memRead  in  1  load request
- memWrite  in  1  store request
- memToReg  in  1  WB select
- regWrite  in  1  WB enable
- dmemReq  out  1  data-bus request
- dmemWe  out  1  write enable
- dmemAddr  out  32  byte address
- dmemWdata  out  32  lane-aligned store data
- dmemWstrb  out  4  byte strobes
- dmemReady  in  1  access-complete handshake
- dmemRdata  in  32  read word, valid when dmemReady=1
- memStall  out  1  hold EX/MEM and earlier stages
- misalignFault  out  1  registered one-cycle fault pulse
- memDataOut  out  32  extended load data to WB
- aluResultOut  out  32  ALU value to WB
- rdOut  out  5  destination register to WB
- memToRegOut  out  1  WB select
- regWriteOut  out  1  WB enable

Function
REQ-003 memSize encodings SHALL be: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; any other code SHALL be treated as word.
REQ-004 An access SHALL be memRead|memWrite; if both are set, the access SHALL be treated as a load.
REQ-005 An access SHALL be misaligned when it is a half with addr[0]=1, or a word with addr[1:0]!=0.
REQ-006 The FSM SHALL have states IDLE and WAIT; reset state SHALL be IDLE.
REQ-007 In IDLE, an aligned access SHALL drive dmemReq=1 combinationally in the same cycle.
- If dmemReady=1 that cycle: the access completes and the FSM stays in IDLE.
- Otherwise: the FSM moves to WAIT.
REQ-008 In WAIT, dmemReq SHALL stay at 1 with dmemAddr, dmemWe, dmemWdata and dmemWstrb stable; on dmemReady=1 the FSM SHALL return to IDLE.
REQ-009 memStall SHALL equal dmemReq & ~dmemReady.
REQ-010 Upstream SHALL hold all inputs constant while memStall=1.
REQ-011 dmemAddr SHALL equal aluResult.
REQ-012 Store strobes SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-013 dmemWdata SHALL carry the store byte replicated 4x for byte stores, the half replicated 2x for half stores, and the full word for word stores.
REQ-014 For loads, dmemWstrb SHALL be 0 and dmemWe SHALL be 0.
REQ-015 Load data SHALL be dmemRdata >> (8*addr[1:0]), then sign- or zero-extended per memSize.
REQ-016 The MEM/WB output registers SHALL update on each clk edge with memStall=0, capturing aluResult, rd, memToReg, regWrite and the extended load data; memDataOut SHALL be 0 for non-loads.
REQ-017 On an edge with memStall=1, the output registers SHALL load a bubble: regWriteOut=0, memToRegOut=0, and other outputs unchanged.
REQ-018 A misaligned access SHALL assert no dmemReq and no stall, SHALL set misalignFault=1 for exactly one cycle after the edge, and SHALL register regWriteOut=0.
REQ-019 An instruction that is not an access SHALL pass through with one-cycle latency and no stall.
REQ-020 Minimum access latency SHALL be one cycle (same-cycle ready); for each extra cycle dmemReady is low, one stall cycle SHALL be added.

Reset
REQ-021 While resetn=0, state SHALL be IDLE, dmemReq SHALL be 0 immediately (asynchronously), and all registered outputs SHALL be 0, independent of clk.
REQ-022 If reset asserts in WAIT, the outstanding access SHALL be abandoned, and no stale dmemReady SHALL be consumed after release.
REQ-023 After resetn deasserts, the first access SHALL begin on the next rising edge.

Structure
REQ-024 A shared package mem_pkg SHALL hold the memSize encodings (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) and the FSM state enum.
REQ-025 Load extraction and extension SHALL live in one combinational sub-module, load_align (inputs rdata, addr[1:0], size; output 32-bit result).

Verification
REQ-026 The bench SHALL cover at least these scenarios:
- SB, addr 0x1003, data 0xA5 -> dmemWstrb=1000, dmemWdata=0xA5A5A5A5, regWriteOut=0.
- LB, addr 0x2002, rdata 0x12F34567 -> memDataOut=0xFFFFFFF3; LBU at the same address -> 0x000000F3.
- LW with dmemReady low for 3 cycles -> memStall high for exactly 3 cycles, 3 bubbles, dmemReq stable, then memDataOut=rdata.
- LH at addr 0x0001 -> no dmemReq, misalignFault pulses one cycle, regWriteOut=0.
- resetn pulsed low in WAIT -> dmemReq drops without a clock edge, outputs are 0, the next load completes normally.
- Back-to-back LW/SW/ADD with dmemReady=1 constantly -> zero stalls, one result per cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: size codes, FSM states and the
// helper that folds a funct3 size code into an access width.
package mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned REG_W  = 5;

  localparam logic [SIZE_W-1:0] MEM_B  = 3'b000;
  localparam logic [SIZE_W-1:0] MEM_H  = 3'b001;
  localparam logic [SIZE_W-1:0] MEM_W  = 3'b010;
  localparam logic [SIZE_W-1:0] MEM_BU = 3'b100;
  localparam logic [SIZE_W-1:0] MEM_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_kind_e;

  // Unlisted size codes are treated as word accesses.
  function automatic size_kind_e size_kind(input logic [SIZE_W-1:0] size);
    case (size)
      MEM_B, MEM_BU: size_kind = SZ_BYTE;
      MEM_H, MEM_HU: size_kind = SZ_HALF;
      default:       size_kind = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: shifts the read word down to the addressed byte lane
// and sign- or zero-extends according to the size code.
// Ports: rdata (read word), addr (byte offset), size (funct3), result.
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0]   rdata,
  input  logic [1:0]        addr,
  input  logic [SIZE_W-1:0] size,
  output logic [XLEN-1:0]   result
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {addr, 3'b000};

  always_comb begin
    result = shifted;
    case (size)
      MEM_B:   result = {{24{shifted[7]}}, shifted[7:0]};
      MEM_BU:  result = {24'h000000, shifted[7:0]};
      MEM_H:   result = {{16{shifted[15]}}, shifted[15:0]};
      MEM_HU:  result = {16'h0000, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives the data bus for loads/stores, stalls the
// pipeline while the bus is busy, flags misaligned accesses and registers
// the MEM/WB payload.
// Ports: clk/resetn; EX/MEM inputs (aluResult, aluOperand2, rd, memSize,
// memRead, memWrite, memToReg, regWrite); data bus (dmemReq, dmemWe,
// dmemAddr, dmemWdata, dmemWstrb, dmemReady, dmemRdata); memStall;
// misalignFault; MEM/WB outputs (memDataOut, aluResultOut, rdOut,
// memToRegOut, regWriteOut).
module mem_stage
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [XLEN-1:0]   aluResult,
  input  logic [XLEN-1:0]   aluOperand2,
  input  logic [REG_W-1:0]  rd,
  input  logic [SIZE_W-1:0] memSize,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              memToReg,
  input  logic              regWrite,
  output logic              dmemReq,
  output logic              dmemWe,
  output logic [XLEN-1:0]   dmemAddr,
  output logic [XLEN-1:0]   dmemWdata,
  output logic [STRB_W-1:0] dmemWstrb,
  input  logic              dmemReady,
  input  logic [XLEN-1:0]   dmemRdata,
  output logic              memStall,
  output logic              misalignFault,
  output logic [XLEN-1:0]   memDataOut,
  output logic [XLEN-1:0]   aluResultOut,
  output logic [REG_W-1:0]  rdOut,
  output logic              memToRegOut,
  output logic              regWriteOut
);

  mem_state_e       state_q;
  size_kind_e       kind;
  logic             access;
  logic             is_store;
  logic             misalign;
  logic [XLEN-1:0]  load_data;

  logic             fault_q;
  logic [XLEN-1:0]  mem_data_q;
  logic [XLEN-1:0]  alu_result_q;
  logic [REG_W-1:0] rd_q;
  logic             mem_to_reg_q;
  logic             reg_write_q;

  // Access decode; a simultaneous read and write counts as a load.
  assign kind     = size_kind(memSize);
  assign access   = memRead | memWrite;
  assign is_store = memWrite & ~memRead;
  assign misalign = access & (((kind == SZ_HALF) & aluResult[0]) |
                              ((kind == SZ_WORD) & (aluResult[1:0] != 2'b00)));

  // The request is gated by resetn so it drops without waiting for a clock.
  assign dmemReq  = resetn & access & ~misalign;
  assign dmemWe   = dmemReq & is_store;
  assign dmemAddr = aluResult;
  assign memStall = dmemReq & ~dmemReady;

  // Store lane steering: strobes and replicated write data.
  always_comb begin
    dmemWstrb = '0;
    dmemWdata = '0;
    if (dmemWe) begin
      case (kind)
        SZ_BYTE: begin
          dmemWstrb = STRB_W'(4'b0001) << aluResult[1:0];
          dmemWdata = {4{aluOperand2[7:0]}};
        end
        SZ_HALF: begin
          dmemWstrb = STRB_W'(4'b0011) << aluResult[1:0];
          dmemWdata = {2{aluOperand2[15:0]}};
        end
        default: begin
          dmemWstrb = 4'b1111;
          dmemWdata = aluOperand2;
        end
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (dmemRdata),
    .addr   (aluResult[1:0]),
    .size   (memSize),
    .result (load_data)
  );

  // Access FSM and MEM/WB register; a stalled edge inserts a bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      fault_q      <= 1'b0;
      mem_data_q   <= '0;
      alu_result_q <= '0;
      rd_q         <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (memStall) state_q <= WAIT;
        WAIT:    if (!memStall) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (memStall) begin
        fault_q      <= 1'b0;
        mem_to_reg_q <= 1'b0;
        reg_write_q  <= 1'b0;
      end else begin
        fault_q      <= misalign;
        mem_data_q   <= (memRead & ~misalign) ? load_data : '0;
        alu_result_q <= aluResult;
        rd_q         <= rd;
        mem_to_reg_q <= memToReg;
        reg_write_q  <= regWrite & ~misalign;
      end
    end
  end

  assign misalignFault = fault_q;
  assign memDataOut    = mem_data_q;
  assign aluResultOut  = alu_result_q;
  assign rdOut         = rd_q;
  assign memToRegOut   = mem_to_reg_q;
  assign regWriteOut   = reg_write_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads, wait states, misalignment,
// reset during an outstanding access and back-to-back traffic.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] aluResult, aluOperand2, dmemRdata;
  logic [4:0]  rd;
  logic [2:0]  memSize;
  logic        memRead, memWrite, memToReg, regWrite, dmemReady;
  logic        dmemReq, dmemWe, memStall, misalignFault, memToRegOut, regWriteOut;
  logic [31:0] dmemAddr, dmemWdata, memDataOut, aluResultOut;
  logic [3:0]  dmemWstrb;
  logic [4:0]  rdOut;

  int vectors = 0;
  int miscompares = 0;
  int stall_cycles;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .aluResult(aluResult), .aluOperand2(aluOperand2), .rd(rd),
    .memSize(memSize), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .regWrite(regWrite),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemWdata(dmemWdata), .dmemWstrb(dmemWstrb),
    .dmemReady(dmemReady), .dmemRdata(dmemRdata),
    .memStall(memStall), .misalignFault(misalignFault),
    .memDataOut(memDataOut), .aluResultOut(aluResultOut), .rdOut(rdOut),
    .memToRegOut(memToRegOut), .regWriteOut(regWriteOut)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                       input logic [2:0] sz, input logic rdn, input logic wr,
                       input logic m2r, input logic rw);
    aluResult = a; aluOperand2 = d; rd = r; memSize = sz;
    memRead = rdn; memWrite = wr; memToReg = m2r; regWrite = rw;
  endtask

  // Move to the next falling edge and let combinational outputs settle.
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic past_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a pending aligned load: request must stay low.
    resetn = 1'b0; dmemReady = 1'b1; dmemRdata = 32'h0;
    drive(32'h0, 32'h0, 5'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("rst_req", 32'(dmemReq), 32'h0);
    chk("rst_stall", 32'(memStall), 32'h0);
    chk("rst_rw", 32'(regWriteOut), 32'h0);
    chk("rst_data", memDataOut, 32'h0);
    chk("rst_alu", aluResultOut, 32'h0);
    chk("rst_fault", 32'(misalignFault), 32'h0);
    to_neg(); to_neg();
    resetn = 1'b1;

    // SB 0x1003
    drive(32'h1003, 32'h000000A5, 5'd3, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("sb_req", 32'(dmemReq), 32'h1);
    chk("sb_we", 32'(dmemWe), 32'h1);
    chk("sb_strb", 32'(dmemWstrb), 32'h8);
    chk("sb_wdata", dmemWdata, 32'hA5A5A5A5);
    chk("sb_addr", dmemAddr, 32'h1003);
    chk("sb_stall", 32'(memStall), 32'h0);
    past_pos();
    chk("sb_rw", 32'(regWriteOut), 32'h0);
    chk("sb_aluout", aluResultOut, 32'h1003);

    // SH 0x0002
    to_neg();
    drive(32'h0002, 32'h00001234, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("sh_strb", 32'(dmemWstrb), 32'hC);
    chk("sh_wdata", dmemWdata, 32'h12341234);
    past_pos();

    // LB / LBU 0x2002
    to_neg();
    dmemRdata = 32'h12F34567;
    drive(32'h2002, 32'h0, 5'd5, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("lb_req", 32'(dmemReq), 32'h1);
    chk("lb_we", 32'(dmemWe), 32'h0);
    chk("lb_strb", 32'(dmemWstrb), 32'h0);
    past_pos();
    chk("lb_data", memDataOut, 32'hFFFFFFF3);
    chk("lb_rw", 32'(regWriteOut), 32'h1);
    chk("lb_rd", 32'(rdOut), 32'd5);
    chk("lb_m2r", 32'(memToRegOut), 32'h1);
    to_neg();
    memSize = 3'b100;
    past_pos();
    chk("lbu_data", memDataOut, 32'h000000F3);

    // LW 0x3000 with three wait cycles
    to_neg();
    dmemReady = 1'b0; dmemRdata = 32'h0;
    drive(32'h3000, 32'h0, 5'd7, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    stall_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (memStall) stall_cycles++;
      chk("lw_wait_req", 32'(dmemReq), 32'h1);
      chk("lw_wait_addr", dmemAddr, 32'h3000);
      past_pos();
      chk("lw_bubble_rw", 32'(regWriteOut), 32'h0);
      chk("lw_bubble_m2r", 32'(memToRegOut), 32'h0);
      chk("lw_bubble_alu", aluResultOut, 32'h2002);
      to_neg();
    end
    dmemReady = 1'b1; dmemRdata = 32'hCAFEBABE;
    #1;
    if (memStall) stall_cycles++;
    chk("lw_stall_cnt", 32'(stall_cycles), 32'd3);
    past_pos();
    chk("lw_data", memDataOut, 32'hCAFEBABE);
    chk("lw_rw", 32'(regWriteOut), 32'h1);
    chk("lw_rd", 32'(rdOut), 32'd7);

    // LH 0x0001 misaligned
    to_neg();
    drive(32'h0001, 32'h0, 5'd9, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("lh_mis_req", 32'(dmemReq), 32'h0);
    chk("lh_mis_stall", 32'(memStall), 32'h0);
    past_pos();
    chk("lh_mis_fault", 32'(misalignFault), 32'h1);
    chk("lh_mis_rw", 32'(regWriteOut), 32'h0);
    to_neg();
    drive(32'h00000077, 32'h0, 5'd4, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    past_pos();
    chk("nop_fault_clr", 32'(misalignFault), 32'h0);
    chk("nop_rw", 32'(regWriteOut), 32'h1);
    chk("nop_data", memDataOut, 32'h0);
    chk("nop_alu", aluResultOut, 32'h77);

    // Reset asserted while waiting on LW 0x4000
    to_neg();
    dmemReady = 1'b0;
    drive(32'h4000, 32'h0, 5'd2, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("wait_stall", 32'(memStall), 32'h1);
    past_pos();
    #1;
    resetn = 1'b0;
    #1;
    chk("wrst_req", 32'(dmemReq), 32'h0);
    chk("wrst_stall", 32'(memStall), 32'h0);
    chk("wrst_alu", aluResultOut, 32'h0);
    chk("wrst_rd", 32'(rdOut), 32'h0);
    to_neg();
    resetn = 1'b1; dmemReady = 1'b1; dmemRdata = 32'h11223344;
    #1;
    chk("wrst_after_req", 32'(dmemReq), 32'h1);
    past_pos();
    chk("wrst_after_data", memDataOut, 32'h11223344);
    chk("wrst_after_rd", 32'(rdOut), 32'd2);

    // Back-to-back LW / SW / ADD with ready held high
    stall_cycles = 0;
    to_neg();
    dmemRdata = 32'hDEADBEEF;
    drive(32'h10, 32'h0, 5'd1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    #1; if (memStall) stall_cycles++;
    past_pos();
    chk("b2b_lw_data", memDataOut, 32'hDEADBEEF);
    to_neg();
    drive(32'h14, 32'h00000055, 5'd0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    #1; if (memStall) stall_cycles++;
    chk("b2b_sw_strb", 32'(dmemWstrb), 32'hF);
    chk("b2b_sw_wdata", dmemWdata, 32'h00000055);
    past_pos();
    chk("b2b_sw_rw", 32'(regWriteOut), 32'h0);
    chk("b2b_sw_data", memDataOut, 32'h0);
    to_neg();
    drive(32'h99, 32'h0, 5'd6, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    #1; if (memStall) stall_cycles++;
    chk("b2b_add_req", 32'(dmemReq), 32'h0);
    past_pos();
    chk("b2b_add_alu", aluResultOut, 32'h99);
    chk("b2b_add_rd", 32'(rdOut), 32'd6);
    chk("b2b_stalls", 32'(stall_cycles), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
